multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier_pkg.sv | 15 +
 rtl/multiplier_if.sv | 37 +++
 rtl/multiplier_step.sv | 24 ++
 rtl/multiplier.sv | 105 ++++++++++
 tb/tb_multiplier.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: default parameters
// and FSM state encoding. Optional feature macro: MULTIPLIER_OVERFLOW_EN.
package multiplier_pkg;

    localparam int unsigned DEF_QUOTIENT_BITDEPTH = 16;
    localparam int unsigned DEF_DIVISOR_BITDEPTH  = 8;
    localparam int unsigned DEF_MULT_STEP         = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiplier_if.sv
// Operand/result handshake bundle for the multiplier.
// o_overflow exists only when MULTIPLIER_OVERFLOW_EN is defined.
interface multiplier_if
    import multiplier_pkg::*;
#(
    parameter int unsigned QUOTIENT_BITDEPTH = DEF_QUOTIENT_BITDEPTH,
    parameter int unsigned DIVISOR_BITDEPTH  = DEF_DIVISOR_BITDEPTH
);
    logic                                        i_input_valid;
    logic                                        o_input_ready;
    logic [QUOTIENT_BITDEPTH-1:0]                i_quotient;
    logic [DIVISOR_BITDEPTH-1:0]                 i_divisor;
    logic [DIVISOR_BITDEPTH-1:0]                 i_remainder;
    logic                                        o_output_valid;
    logic                                        i_output_ready;
    logic [QUOTIENT_BITDEPTH+DIVISOR_BITDEPTH-1:0] o_dividend;
`ifdef MULTIPLIER_OVERFLOW_EN
    logic                                        o_overflow;
`endif

    modport slave (
        input  i_input_valid, i_quotient, i_divisor, i_remainder, i_output_ready,
`ifdef MULTIPLIER_OVERFLOW_EN
        output o_overflow,
`endif
        output o_input_ready, o_output_valid, o_dividend
    );

    modport master (
        output i_input_valid, i_quotient, i_divisor, i_remainder, i_output_ready,
`ifdef MULTIPLIER_OVERFLOW_EN
        input  o_overflow,
`endif
        input  o_input_ready, o_output_valid, o_dividend
    );

endinterface

// File: rtl/multiplier_step.sv
// Combinational partial-product sum for one CALC cycle: adds the multiplicand
// shifted by k for every set bit k of the current multiplier slice.
module multiplier_step
    import multiplier_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_QUOTIENT_BITDEPTH + DEF_DIVISOR_BITDEPTH,
    parameter int unsigned MULT_STEP = DEF_MULT_STEP
) (
    input  logic [MULT_STEP-1:0] bits,
    input  logic [WIDTH-1:0]     mcand,
    output logic [WIDTH-1:0]     sum
);

    // Sum of gated, shifted multiplicands
    always_comb begin
        sum = '0;
        for (int k = 0; k < int'(MULT_STEP); k++) begin
            if (bits[k]) begin
                sum = sum + (mcand << k);
            end
        end
    end

endmodule

// File: rtl/multiplier.sv
// Sequential shift-and-add multiplier: o_dividend = quotient*divisor + remainder.
// Consumes MULT_STEP multiplier bits per clock; result after N = Q/MULT_STEP clocks.
// Optional feature macro: MULTIPLIER_OVERFLOW_EN adds o_overflow.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int unsigned QUOTIENT_BITDEPTH = DEF_QUOTIENT_BITDEPTH,
    parameter int unsigned DIVISOR_BITDEPTH  = DEF_DIVISOR_BITDEPTH,
    parameter int unsigned MULT_STEP         = DEF_MULT_STEP
) (
    input  logic        i_sclk,
    input  logic        i_rst,
    multiplier_if.slave bus
);

    localparam int unsigned WIDTH  = QUOTIENT_BITDEPTH + DIVISOR_BITDEPTH;
    localparam int unsigned NSTEPS = QUOTIENT_BITDEPTH / MULT_STEP;
    localparam int unsigned CNT_W  = $clog2(NSTEPS + 1);

    state_t                       state;
    logic [QUOTIENT_BITDEPTH-1:0] mplier;
    logic [WIDTH-1:0]             mcand;
    logic [WIDTH-1:0]             acc;
    logic [CNT_W-1:0]             cnt;
    logic                         input_ready;
    logic                         output_valid;
    logic [WIDTH-1:0]             step_sum;
    logic [WIDTH-1:0]             acc_next_c;
`ifdef MULTIPLIER_OVERFLOW_EN
    logic                         overflow;
`endif

    multiplier_step #(
        .WIDTH     (WIDTH),
        .MULT_STEP (MULT_STEP)
    ) u_step (
        .bits  (mplier[MULT_STEP-1:0]),
        .mcand (mcand),
        .sum   (step_sum)
    );

    assign acc_next_c = acc + step_sum;

    // Control FSM and datapath registers
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            state        <= IDLE;
            mplier       <= '0;
            mcand        <= '0;
            acc          <= '0;
            cnt          <= '0;
            input_ready  <= 1'b1;
            output_valid <= 1'b0;
`ifdef MULTIPLIER_OVERFLOW_EN
            overflow     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_input_valid) begin
                        mplier      <= bus.i_quotient;
                        mcand       <= WIDTH'(bus.i_divisor);
                        acc         <= WIDTH'(bus.i_remainder);
                        cnt         <= '0;
                        input_ready <= 1'b0;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next_c;
                    mplier <= mplier >> MULT_STEP;
                    mcand  <= mcand << MULT_STEP;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NSTEPS - 1)) begin
                        output_valid <= 1'b1;
                        state        <= DONE;
`ifdef MULTIPLIER_OVERFLOW_EN
                        overflow     <= |acc_next_c[WIDTH-1:QUOTIENT_BITDEPTH];
`endif
                    end
                end
                DONE: begin
                    if (bus.i_output_ready) begin
                        output_valid <= 1'b0;
                        input_ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    output_valid <= 1'b0;
                    input_ready  <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_input_ready  = input_ready;
    assign bus.o_output_valid = output_valid;
    assign bus.o_dividend     = acc;
`ifdef MULTIPLIER_OVERFLOW_EN
    assign bus.o_overflow     = overflow;
`endif

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier (Q=8, D=4, MULT_STEP=2, N=4).
module tb_multiplier;

    localparam int unsigned QW = 8;
    localparam int unsigned DW = 4;
    localparam int unsigned ST = 2;
    localparam int unsigned N  = QW / ST;

    logic i_sclk = 1'b0;
    logic i_rst;
    int   total = 0;
    int   bad   = 0;

    multiplier_if #(.QUOTIENT_BITDEPTH(QW), .DIVISOR_BITDEPTH(DW)) bus ();

    multiplier #(
        .QUOTIENT_BITDEPTH (QW),
        .DIVISOR_BITDEPTH  (DW),
        .MULT_STEP         (ST)
    ) dut (
        .i_sclk (i_sclk),
        .i_rst  (i_rst),
        .bus    (bus)
    );

    always #5 i_sclk = ~i_sclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_mul(input int q, input int d, input int r);
        return 32'(q * d + r);
    endfunction

    task automatic tick();
        @(posedge i_sclk);
        #1;
    endtask

    // Accept one op, measure latency, check result; consumes it if ready is high.
    task automatic do_op(input string tag, input int q, input int d, input int r);
        int lat;
        logic [31:0] expv;
        expv = ref_mul(q, d, r);
        check({tag, "_ready_before"}, 32'(bus.o_input_ready), 32'd1);
        bus.i_quotient    = QW'(q);
        bus.i_divisor     = DW'(d);
        bus.i_remainder   = DW'(r);
        bus.i_input_valid = 1'b1;
        tick();
        bus.i_input_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.o_output_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(N));
        check({tag, "_result"}, 32'(bus.o_dividend), expv);
`ifdef MULTIPLIER_OVERFLOW_EN
        check({tag, "_overflow"}, 32'(bus.o_overflow), 32'(expv >= 32'(1 << QW)));
`endif
        if (bus.i_output_ready) begin
            tick();
            check({tag, "_valid_one_cycle"}, 32'(bus.o_output_valid), 32'd0);
            check({tag, "_idle_after"}, 32'(bus.o_input_ready), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] expq[$];
        logic [31:0] expv;
        int          seen;
        int          cyc;
        int          last_t;
        int          results;
        logic        was_ready;
        int          q, d, r;

        i_rst              = 1'b1;
        bus.i_input_valid  = 1'b0;
        bus.i_output_ready = 1'b1;
        bus.i_quotient     = '0;
        bus.i_divisor      = '0;
        bus.i_remainder    = '0;
        tick();
        tick();
        check("rst_input_ready", 32'(bus.o_input_ready), 32'd1);
        check("rst_output_valid", 32'(bus.o_output_valid), 32'd0);
        check("rst_dividend", 32'(bus.o_dividend), 32'd0);
        i_rst = 1'b0;
        tick();

        // Directed corner cases
        do_op("basic", 13, 5, 3);
        do_op("max", 255, 15, 14);
        do_op("zero_mul", 0, 9, 7);
        do_op("zero_mcand", 200, 0, 5);

        // Random operands
        for (int i = 0; i < 10; i++) begin
            do_op("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)));
        end

        // Backpressure: hold result for 3 cycles, ignore new valid meanwhile
        bus.i_output_ready = 1'b0;
        do_op("bp", 200, 11, 9);
        held = 32'(bus.o_dividend);
        check("bp_value", held, ref_mul(200, 11, 9));
        bus.i_quotient    = 8'd1;
        bus.i_divisor     = 4'd1;
        bus.i_remainder   = 4'd1;
        bus.i_input_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_held", 32'(bus.o_dividend), held);
            check("bp_valid", 32'(bus.o_output_valid), 32'd1);
            check("bp_not_ready", 32'(bus.o_input_ready), 32'd0);
        end
        bus.i_input_valid  = 1'b0;
        bus.i_output_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(bus.o_output_valid), 32'd0);
        check("bp_release_ready", 32'(bus.o_input_ready), 32'd1);
        do_op("after_bp", 77, 3, 2);

        // Reset two cycles into an operation
        bus.i_quotient    = 8'd100;
        bus.i_divisor     = 4'd7;
        bus.i_remainder   = 4'd1;
        bus.i_input_valid = 1'b1;
        tick();
        bus.i_input_valid = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst_ready", 32'(bus.o_input_ready), 32'd1);
        check("midrst_valid", 32'(bus.o_output_valid), 32'd0);
        check("midrst_acc", 32'(bus.o_dividend), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.o_output_valid) seen++;
        end
        check("midrst_no_output", 32'(seen), 32'd0);
        do_op("after_rst", 6, 6, 0);

        // Back-to-back with valid held high and operands changing every cycle
        q = int'($urandom_range(0, 255));
        d = int'($urandom_range(0, 15));
        r = int'($urandom_range(0, 15));
        bus.i_quotient    = QW'(q);
        bus.i_divisor     = DW'(d);
        bus.i_remainder   = DW'(r);
        bus.i_input_valid = 1'b1;
        cyc     = 0;
        last_t  = -1;
        results = 0;
        while (results < 5 && cyc < 80) begin
            was_ready = bus.o_input_ready;
            tick();
            cyc++;
            if (was_ready) expq.push_back(ref_mul(q, d, r));
            q = int'($urandom_range(0, 255));
            d = int'($urandom_range(0, 15));
            r = int'($urandom_range(0, 15));
            bus.i_quotient  = QW'(q);
            bus.i_divisor   = DW'(d);
            bus.i_remainder = DW'(r);
            if (bus.o_output_valid) begin
                expv = (expq.size() > 0) ? expq.pop_front() : 32'hFFFF_FFFF;
                check("b2b_result", 32'(bus.o_dividend), expv);
                if (last_t >= 0) check("b2b_spacing", 32'(cyc - last_t), 32'(N + 2));
                last_t = cyc;
                results++;
            end
        end
        check("b2b_count", 32'(results), 32'd5);
        bus.i_input_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.o_output_valid) begin
                expv = (expq.size() > 0) ? expq.pop_front() : 32'hFFFF_FFFF;
                check("b2b_drain", 32'(bus.o_dividend), expv);
            end
        end
        check("b2b_queue_empty", 32'(expq.size()), 32'd0);
        check("final_idle", 32'(bus.o_input_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
